dmc_encode: RTL and testbench
=============================

# dmc_encode

Differential-Manchester (DMC) line encoder; transmit-side counterpart of the DMC decoder. Runs at 98 MHz (`clk_i`) and serializes one frame: a programmable preamble, then payload bits pulled from an upstream valid/ready stream, then a closing tail. Every half-cell is an integer number of `clk_i` cycles, so edge intervals match the decoder's short/long classification.

## Interface
- `HALF_W`, default 8: width of the half-cell period counter.
- `clk_i` in 1: 98 MHz clock.
- `reset_n_period` in 1: asynchronous, active-low reset.
- `enable` in 1: transmitter enable; deassertion aborts any frame in progress.
- `start` in 1: frame request; sampled only in ST_IDLE.
- `half_period` in HALF_W: half-cell length in `clk_i` cycles, H; values 0 and 1 are treated as 2.
- `preamble_pat` in 8: preamble bits, sent MSB first.
- `preamble_len` in 4: preamble bit count P; values above 8 are treated as 8.
- `frame_len` in 8: payload bit count L; 0 makes `start` ignored.
- `bit_data` in 1: payload bit.
- `bit_vld` in 1: payload bit valid.
- `bit_rdy` out 1: payload fetch strobe.
- `line_o` out 1: encoded line level.
- `line_oe` out 1: line driver enable.
- `busy` out 1: frame in progress.
- `frame_done` out 1: one-cycle pulse at normal frame end.
- `underrun` out 1: one-cycle pulse when a fetch found `bit_vld` low.
- `aborted` out 1: one-cycle pulse when `enable` drops mid-frame.

## Operation
- Encoding:
  - Each bit cell is two half-cells of H cycles.
  - `line_o` toggles at the start of every cell.
  - Bit 0 adds a mid-cell toggle, giving two short intervals of H.
  - Bit 1 has no mid-cell toggle, giving one long interval of 2H.
- Shadow registers: H (clamped), `preamble_pat`, P (clamped) and L are captured on the accepted `start` and held for the whole frame. Input changes mid-frame have no effect.
- States:
  - ST_IDLE: `start && enable && L!=0` -> ST_ARM.
  - ST_ARM: exactly one cycle. `line_oe` rises. -> ST_PRE if P!=0, else ST_PAY.
  - ST_PRE: sends P preamble cells. -> ST_PAY after the last one.
  - ST_PAY: sends L payload cells. -> ST_TAIL after the last one.
  - ST_TAIL: one closing toggle at tail start, then the line holds for 2 cells (4H cycles). -> ST_IDLE.
  - The return to ST_IDLE drops `line_oe` and `busy` and pulses `frame_done`.
- Counters:
  - Half-cell counter runs 0..H-1 with a half flag.
  - Bit index runs 0..P-1 in ST_PRE and 0..L-1 in ST_PAY, with no wrap.
- Payload fetch:
  - `bit_rdy` is decoded from registered state only; there is no combinational path from `bit_vld`.
  - `bit_rdy` is high for exactly one cycle, in the last cycle before each payload cell. That is the ST_ARM cycle when P=0; otherwise it is the final cycle of the preceding cell.
  - A transfer happens when `bit_vld && bit_rdy`.
  - If `bit_vld` is low in the fetch cycle: `underrun` pulses, bit 1 is transmitted, and the frame continues. There is no retry and the late bit is not consumed.
- Abort: `enable` low in any state other than ST_IDLE takes effect the next cycle:
  - state returns to ST_IDLE;
  - `line_oe`, `busy` = 0;
  - `aborted` pulses;
  - `frame_done` does not pulse.
- Line level: `line_o` is never forced by frame end or abort. It retains its last level across frames, and each frame's first toggle is relative to that level.
- `start` while busy is ignored; no queuing.
- Simultaneous `start` and `enable` fall: no frame starts.
- Reset (async, any time, including mid-frame):
  - all outputs are 0;
  - state is ST_IDLE;
  - counters and shadow registers are cleared;
  - no `frame_done` or `aborted` pulse.

## Timing
- Accepted `start` sampled at cycle T.
- T+1: ST_ARM. `line_oe` = `busy` = 1. `line_o` unchanged.
- T+2: first cell-start toggle.
- Cell k starts at T+2+2H·k; its mid toggle, if any, is at T+2+2H·k+H.
- Let N = P+L.
  - Tail toggle at T+2+2H·N.
  - `line_oe` and `busy` fall at T+2+2H·(N+2), with `frame_done` high in that same cycle.
- The next `start` can be accepted in the cycle after `frame_done`.
- All outputs are registered. Toggles occur on the cycle the counter reaches 0.
- `underrun` pulses in the cycle after the failed fetch cycle.

## Test plan
- Nominal frame: H=4, `preamble_pat`=8'hAC, P=8, L=4, payload 1,0,1,1, `bit_vld` always high.
  - Required `line_o` edge intervals: 8,4,4,8,4,4,8,8,4,4,4,4,8,4,4,8,8.
  - Then the tail toggle; `line_oe` falls 16 cycles later with `frame_done`.
  - Exactly 4 `bit_rdy` pulses.
- Underrun: same setup, `bit_vld` low only at the 2nd fetch.
  - One `underrun` pulse.
  - Payload intervals 8,8,8,8.
  - Frame completes normally.
- Clamps: `half_period`=0 and then 1, with P=9 → 2-cycle half-cells and an 8-bit preamble.
- P=0, L=2, bits 0,0:
  - `bit_rdy` high in the ST_ARM cycle (T+1);
  - toggles at T+2, T+4, T+6, T+8, and the tail toggle at T+10;
  - `line_oe` falls at T+18.
- Abort: `enable` low during payload cell 2.
  - Next cycle: `line_oe`=`busy`=0, one `aborted` pulse, no `frame_done`, `line_o` holds.
  - A new `start` after `enable` returns produces a full nominal frame.
- Reset asserted mid-preamble: all outputs 0 immediately.
  - After release, `start` is needed to transmit; `start` with L=0 is ignored.

Source files
------------

// File: rtl/dmc_encode.sv
// Differential-Manchester line encoder. Sends one frame made of a preamble, a payload
// pulled from a valid/ready stream, and a closing tail. Every half-cell is H clk_i cycles.
module dmc_encode #(
  parameter int unsigned HALF_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_n_period,
  input  logic              enable,
  input  logic              start,
  input  logic [HALF_W-1:0] half_period,
  input  logic [7:0]        preamble_pat,
  input  logic [3:0]        preamble_len,
  input  logic [7:0]        frame_len,
  input  logic              bit_data,
  input  logic              bit_vld,
  output logic              bit_rdy,
  output logic              line_o,
  output logic              line_oe,
  output logic              busy,
  output logic              frame_done,
  output logic              underrun,
  output logic              aborted
);

  typedef enum logic [2:0] {StIdle, StArm, StPre, StPay, StTail} state_e;

  state_e            state_q;
  logic [HALF_W-1:0] cnt_q;
  logic              half_q;
  logic [7:0]        idx_q;
  logic [HALF_W-1:0] h_q;
  logic [7:0]        pat_q;
  logic [3:0]        p_q;
  logic [7:0]        l_q;
  logic              cur_bit_q;

  logic [HALF_W-1:0] h_clamp;
  logic [3:0]        p_clamp;
  logic              accept;
  logic              last_cyc;
  logic              cell_end;
  logic              pre_last;
  logic              pay_last;
  logic              cell_bit;
  logic              fetch_next;
  logic [2:0]        pre_sel;

  // Clamped frame parameters, cell position decode and the bit of the current cell.
  always_comb begin
    h_clamp    = (half_period < HALF_W'(2)) ? HALF_W'(2) : half_period;
    p_clamp    = (preamble_len > 4'd8) ? 4'd8 : preamble_len;
    accept     = (state_q == StIdle) && start && enable && (frame_len != 8'd0);
    last_cyc   = (cnt_q == h_q - HALF_W'(1));
    cell_end   = last_cyc && half_q;
    pre_last   = (idx_q == {4'd0, p_q} - 8'd1);
    pay_last   = (idx_q == l_q - 8'd1);
    pre_sel    = 3'd7 - idx_q[2:0];
    cell_bit   = 1'b1;
    if (state_q == StPre) begin
      cell_bit = pat_q[pre_sel];
    end else if (state_q == StPay) begin
      cell_bit = cur_bit_q;
    end
    // One cycle ahead of the final cycle of a cell that is followed by a payload cell.
    fetch_next = (cnt_q == h_q - HALF_W'(2)) && half_q &&
                 (((state_q == StPre) && pre_last) || ((state_q == StPay) && !pay_last));
  end

  // Frame sequencer; every output is a register updated here.
  always_ff @(posedge clk_i or negedge reset_n_period) begin
    if (!reset_n_period) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      half_q     <= 1'b0;
      idx_q      <= '0;
      h_q        <= '0;
      pat_q      <= '0;
      p_q        <= '0;
      l_q        <= '0;
      cur_bit_q  <= 1'b0;
      bit_rdy    <= 1'b0;
      line_o     <= 1'b0;
      line_oe    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      aborted    <= 1'b0;
      bit_rdy    <= 1'b0;
      // A missing payload bit is sent as 1; the stream is not retried.
      if (bit_rdy) begin
        cur_bit_q <= bit_vld ? bit_data : 1'b1;
        underrun  <= !bit_vld && enable;
      end
      if ((state_q != StIdle) && !enable) begin
        state_q <= StIdle;
        line_oe <= 1'b0;
        busy    <= 1'b0;
        aborted <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (accept) begin
              state_q <= StArm;
              h_q     <= h_clamp;
              pat_q   <= preamble_pat;
              p_q     <= p_clamp;
              l_q     <= frame_len;
              cnt_q   <= '0;
              half_q  <= 1'b0;
              idx_q   <= '0;
              line_oe <= 1'b1;
              busy    <= 1'b1;
              bit_rdy <= (p_clamp == 4'd0);
            end
          end
          StArm: begin
            state_q <= (p_q != 4'd0) ? StPre : StPay;
            line_o  <= ~line_o;
            cnt_q   <= '0;
            half_q  <= 1'b0;
            idx_q   <= '0;
          end
          StPre, StPay: begin
            bit_rdy <= fetch_next;
            if (cell_end) begin
              line_o <= ~line_o;
              cnt_q  <= '0;
              half_q <= 1'b0;
              if ((state_q == StPre) && pre_last) begin
                state_q <= StPay;
                idx_q   <= '0;
              end else if ((state_q == StPay) && pay_last) begin
                state_q <= StTail;
                idx_q   <= '0;
              end else begin
                idx_q <= idx_q + 8'd1;
              end
            end else if (last_cyc) begin
              cnt_q  <= '0;
              half_q <= 1'b1;
              if (!cell_bit) line_o <= ~line_o;
            end else begin
              cnt_q <= cnt_q + HALF_W'(1);
            end
          end
          StTail: begin
            // Two silent cells after the closing toggle.
            if (cell_end) begin
              cnt_q  <= '0;
              half_q <= 1'b0;
              if (idx_q == 8'd1) begin
                state_q    <= StIdle;
                line_oe    <= 1'b0;
                busy       <= 1'b0;
                frame_done <= 1'b1;
              end else begin
                idx_q <= idx_q + 8'd1;
              end
            end else if (last_cyc) begin
              cnt_q  <= '0;
              half_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + HALF_W'(1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dmc_encode.sv
// Self-checking bench for dmc_encode: expected edge intervals / event times are pushed to a
// scoreboard queue when a frame is launched and popped as the line toggles are observed.
module tb_dmc_encode;

  logic       clk_i = 1'b0;
  logic       reset_n_period = 1'b0;
  logic       enable = 1'b0;
  logic       start = 1'b0;
  logic [7:0] half_period = 8'd4;
  logic [7:0] preamble_pat = 8'h00;
  logic [3:0] preamble_len = 4'd0;
  logic [7:0] frame_len = 8'd0;
  logic       bit_data = 1'b0;
  logic       bit_vld = 1'b0;
  logic       bit_rdy, line_o, line_oe, busy, frame_done, underrun, aborted;

  dmc_encode #(.HALF_W(8)) dut (
    .clk_i          (clk_i),
    .reset_n_period (reset_n_period),
    .enable         (enable),
    .start          (start),
    .half_period    (half_period),
    .preamble_pat   (preamble_pat),
    .preamble_len   (preamble_len),
    .frame_len      (frame_len),
    .bit_data       (bit_data),
    .bit_vld        (bit_vld),
    .bit_rdy        (bit_rdy),
    .line_o         (line_o),
    .line_oe        (line_oe),
    .busy           (busy),
    .frame_done     (frame_done),
    .underrun       (underrun),
    .aborted        (aborted)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int tog_q[$];
  int rdy_q[$];
  int und_q[$];
  int done_cnt, done_c, fall_c, abort_cnt, abort_c;
  logic line_before, line_at1, oe_at1, busy_at1, line_end;
  logic [6:0] snap;
  bit timed_out;
  logic [7:0] pay_bits = 8'h00;
  logic [7:0] vld_mask = 8'hFF;

  // Model: each cell contributes H,H (bit 0) or 2H (bit 1) to the interval sequence.
  task automatic push_cells(input int h, input logic [7:0] pat, input int p,
                            input logic [7:0] bits, input int l);
    logic b;
    for (int i = 0; i < p; i++) begin
      b = pat[7-i];
      if (b) exp_q.push_back(2 * h);
      else begin exp_q.push_back(h); exp_q.push_back(h); end
    end
    for (int i = 0; i < l; i++) begin
      b = bits[i];
      if (b) exp_q.push_back(2 * h);
      else begin exp_q.push_back(h); exp_q.push_back(h); end
    end
  endtask

  // Launches one frame and records what the line does, cycle numbers relative to T.
  task automatic run_frame(input int h_in, input logic [7:0] pat, input int plen,
                           input int flen, input int abort_at, input int reset_at);
    int c;
    int k;
    bit stop;
    logic prev_line, prev_oe;
    tog_q.delete(); rdy_q.delete(); und_q.delete();
    done_cnt = 0; done_c = -1; fall_c = -1; abort_cnt = 0; abort_c = -1;
    timed_out = 1'b0;
    @(negedge clk_i);
    half_period  = 8'(h_in);
    preamble_pat = pat;
    preamble_len = 4'(plen);
    frame_len    = 8'(flen);
    bit_data     = pay_bits[0];
    bit_vld      = vld_mask[0];
    line_before  = line_o;
    prev_line    = line_o;
    prev_oe      = line_oe;
    start        = 1'b1;
    k = 0; c = 0; stop = 1'b0;
    while (!stop) begin
      @(negedge clk_i);
      c++;
      if (c == 1) begin
        start    = 1'b0;
        line_at1 = line_o;
        oe_at1   = line_oe;
        busy_at1 = busy;
      end
      if (line_o !== prev_line) tog_q.push_back(c);
      if (bit_rdy) rdy_q.push_back(c);
      if (underrun) und_q.push_back(c);
      if (frame_done) begin done_cnt++; done_c = c; end
      if (aborted) begin abort_cnt++; abort_c = c; end
      if (prev_oe && !line_oe) fall_c = c;
      prev_line = line_o;
      prev_oe   = line_oe;
      if (k < 8) begin bit_data = pay_bits[k]; bit_vld = vld_mask[k]; end
      else begin bit_data = 1'b0; bit_vld = 1'b0; end
      if (bit_rdy) k++;
      if (abort_at != 0 && c == abort_at) enable = 1'b0;
      if (reset_at != 0 && c == reset_at) begin
        #2 reset_n_period = 1'b0;
        #1 snap = {line_o, line_oe, busy, bit_rdy, frame_done, underrun, aborted};
        stop = 1'b1;
      end else if (c >= 2 && !busy) begin
        line_end = line_o;
        stop = 1'b1;
      end else if (c >= 3000) begin
        timed_out = 1'b1;
        stop = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk_i);
    checks++;
    if ({line_o, line_oe, busy, bit_rdy, frame_done, underrun, aborted} !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, want 0000000",
               {line_o, line_oe, busy, bit_rdy, frame_done, underrun, aborted});
    end
    reset_n_period = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk_i);
    checks++;
    if ({line_o, line_oe, busy} !== 3'd0) begin
      errors++;
      $display("FAIL idle_after_reset: got %b, want 000", {line_o, line_oe, busy});
    end
  endtask

  task automatic test_nominal;
    pay_bits = 8'b0000_1101;
    vld_mask = 8'hFF;
    exp_q.delete();
    push_cells(4, 8'hAC, 8, pay_bits, 4);
    run_frame(4, 8'hAC, 8, 4, 0, 0);
    checks++;
    if (timed_out) begin errors++; $display("FAIL nominal_timeout: frame did not end"); end
    checks++;
    if (oe_at1 !== 1'b1 || busy_at1 !== 1'b1 || line_at1 !== line_before) begin
      errors++;
      $display("FAIL nominal_arm: oe=%b busy=%b line=%b, want 1 1 %b",
               oe_at1, busy_at1, line_at1, line_before);
    end
    checks++;
    if (tog_q.size() == 0 || tog_q[0] !== 2) begin
      errors++;
      $display("FAIL nominal_first_toggle: got %0d, want 2",
               (tog_q.size() == 0) ? -1 : tog_q[0]);
    end
    for (int i = 1; i < tog_q.size(); i++) begin
      int iv;
      int e;
      iv = tog_q[i] - tog_q[i-1];
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL nominal_interval %0d: got %0d, none expected", i, iv);
      end else begin
        e = exp_q.pop_front();
        if (iv !== e) begin
          errors++;
          $display("FAIL nominal_interval %0d: got %0d, want %0d", i, iv, e);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL nominal_missing_intervals: %0d left, want 0", exp_q.size());
    end
    checks++;
    if (tog_q.size() == 0 || tog_q[tog_q.size()-1] !== 98 || fall_c !== 114 || done_c !== 114) begin
      errors++;
      $display("FAIL nominal_tail: last toggle/fall/done got %0d/%0d/%0d, want 98/114/114",
               (tog_q.size() == 0) ? -1 : tog_q[tog_q.size()-1], fall_c, done_c);
    end
    checks++;
    if (rdy_q.size() !== 4 || rdy_q[0] !== 65) begin
      errors++;
      $display("FAIL nominal_rdy: count %0d first %0d, want 4 first 65", rdy_q.size(),
               (rdy_q.size() == 0) ? -1 : rdy_q[0]);
    end
    checks++;
    if (done_cnt !== 1 || und_q.size() !== 0 || abort_cnt !== 0) begin
      errors++;
      $display("FAIL nominal_pulses: done=%0d under=%0d abort=%0d, want 1 0 0",
               done_cnt, und_q.size(), abort_cnt);
    end
  endtask

  task automatic test_underrun;
    pay_bits = 8'b0000_1101;
    vld_mask = 8'b1111_1101;
    exp_q.delete();
    push_cells(4, 8'hAC, 8, 8'b0000_1111, 4);
    run_frame(4, 8'hAC, 8, 4, 0, 0);
    vld_mask = 8'hFF;
    for (int i = 1; i < tog_q.size(); i++) begin
      int iv;
      int e;
      iv = tog_q[i] - tog_q[i-1];
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL underrun_interval %0d: got %0d, none expected", i, iv);
      end else begin
        e = exp_q.pop_front();
        if (iv !== e) begin
          errors++;
          $display("FAIL underrun_interval %0d: got %0d, want %0d", i, iv, e);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0 || timed_out) begin
      errors++;
      $display("FAIL underrun_missing: %0d left timeout=%0d, want 0 0", exp_q.size(), timed_out);
    end
    checks++;
    if (und_q.size() !== 1 || und_q[0] !== 74) begin
      errors++;
      $display("FAIL underrun_pulse: count %0d at %0d, want 1 at 74", und_q.size(),
               (und_q.size() == 0) ? -1 : und_q[0]);
    end
    checks++;
    if (done_cnt !== 1 || done_c !== 114) begin
      errors++;
      $display("FAIL underrun_done: count %0d at %0d, want 1 at 114", done_cnt, done_c);
    end
  endtask

  task automatic test_clamps;
    for (int hv = 0; hv < 2; hv++) begin
      pay_bits = 8'h01;
      exp_q.delete();
      push_cells(2, 8'hAC, 8, pay_bits, 1);
      run_frame(hv, 8'hAC, 9, 1, 0, 0);
      for (int i = 1; i < tog_q.size(); i++) begin
        int iv;
        int e;
        iv = tog_q[i] - tog_q[i-1];
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL clamp_interval h=%0d #%0d: got %0d, none expected", hv, i, iv);
        end else begin
          e = exp_q.pop_front();
          if (iv !== e) begin
            errors++;
            $display("FAIL clamp_interval h=%0d #%0d: got %0d, want %0d", hv, i, iv, e);
          end
        end
      end
      checks++;
      if (exp_q.size() != 0 || done_c !== 46 || fall_c !== 46) begin
        errors++;
        $display("FAIL clamp_end h=%0d: left %0d done %0d fall %0d, want 0 46 46",
                 hv, exp_q.size(), done_c, fall_c);
      end
    end
  endtask

  task automatic test_no_preamble;
    pay_bits = 8'h00;
    exp_q.delete();
    for (int t = 2; t <= 10; t += 2) exp_q.push_back(t);
    run_frame(2, 8'hFF, 0, 2, 0, 0);
    checks++;
    if (rdy_q.size() !== 2 || rdy_q[0] !== 1) begin
      errors++;
      $display("FAIL nopre_rdy: count %0d first %0d, want 2 first 1", rdy_q.size(),
               (rdy_q.size() == 0) ? -1 : rdy_q[0]);
    end
    for (int i = 0; i < tog_q.size(); i++) begin
      int e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL nopre_toggle %0d: got %0d, none expected", i, tog_q[i]);
      end else begin
        e = exp_q.pop_front();
        if (tog_q[i] !== e) begin
          errors++;
          $display("FAIL nopre_toggle %0d: got %0d, want %0d", i, tog_q[i], e);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0 || fall_c !== 18) begin
      errors++;
      $display("FAIL nopre_end: left %0d fall %0d, want 0 18", exp_q.size(), fall_c);
    end
  endtask

  task automatic test_abort;
    logic held;
    pay_bits = 8'b0000_1101;
    run_frame(4, 8'hAC, 8, 4, 84, 0);
    checks++;
    if (fall_c !== 85 || abort_cnt !== 1 || abort_c !== 85 || done_cnt !== 0) begin
      errors++;
      $display("FAIL abort_effect: fall %0d abort %0d@%0d done %0d, want 85 1@85 0",
               fall_c, abort_cnt, abort_c, done_cnt);
    end
    held = line_end;
    repeat (12) @(negedge clk_i);
    checks++;
    if (line_o !== held || busy !== 1'b0 || line_oe !== 1'b0) begin
      errors++;
      $display("FAIL abort_hold: line %b busy %b oe %b, want %b 0 0", line_o, busy, line_oe, held);
    end
    enable = 1'b1;
    exp_q.delete();
    push_cells(4, 8'hAC, 8, pay_bits, 4);
    run_frame(4, 8'hAC, 8, 4, 0, 0);
    for (int i = 1; i < tog_q.size(); i++) begin
      int iv;
      int e;
      iv = tog_q[i] - tog_q[i-1];
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL abort_refr_interval %0d: got %0d, none expected", i, iv);
      end else begin
        e = exp_q.pop_front();
        if (iv !== e) begin
          errors++;
          $display("FAIL abort_refr_interval %0d: got %0d, want %0d", i, iv, e);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0 || done_c !== 114) begin
      errors++;
      $display("FAIL abort_refr_end: left %0d done %0d, want 0 114", exp_q.size(), done_c);
    end
  endtask

  task automatic test_reset_mid;
    logic held;
    pay_bits = 8'b0000_1101;
    run_frame(4, 8'hAC, 8, 4, 0, 20);
    checks++;
    if (snap !== 7'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %b, want 0000000", snap);
    end
    @(negedge clk_i);
    reset_n_period = 1'b1;
    held = line_o;
    repeat (20) @(negedge clk_i);
    checks++;
    if (busy !== 1'b0 || line_oe !== 1'b0 || line_o !== held) begin
      errors++;
      $display("FAIL reset_mid_idle: busy %b oe %b line %b, want 0 0 %b", busy, line_oe, line_o, held);
    end
    frame_len = 8'd0;
    start = 1'b1;
    @(negedge clk_i);
    start = 1'b0;
    repeat (4) @(negedge clk_i);
    checks++;
    if (busy !== 1'b0 || line_oe !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_start: busy %b oe %b, want 0 0", busy, line_oe);
    end
    run_frame(4, 8'hAC, 8, 4, 0, 0);
    checks++;
    if (done_cnt !== 1 || done_c !== 114) begin
      errors++;
      $display("FAIL reset_mid_restart: done %0d at %0d, want 1 at 114", done_cnt, done_c);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_underrun();
    test_clamps();
    test_no_preamble();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
